// File: rtl/fifo_ctrl.sv
// fifo_ctrl: pointer, occupancy, flag and sticky-error controller for a synchronous dual-port RAM FIFO
module fifo_ctrl #(
  parameter int ADDR_WIDTH = 4,
  parameter int AFULL_TH   = 12,
  parameter int AEMPTY_TH  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  wr_req,
  input  logic                  rd_req,
  input  logic                  clr_err,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_waddr,
  output logic                  ram_re,
  output logic [ADDR_WIDTH-1:0] ram_raddr,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow
);
  localparam int CW = ADDR_WIDTH + 1;
  logic [ADDR_WIDTH:0] wptr, rptr;
  always_comb begin
    full         = (count == CW'(2 ** ADDR_WIDTH)) & ((wptr ^ rptr) == {1'b1, {ADDR_WIDTH{1'b0}}});
    empty        = count == '0;
    almost_full  = count >= CW'(AFULL_TH);
    almost_empty = count <= CW'(AEMPTY_TH);
    ram_we       = wr_req & ~full & ~rst & ~flush;
    ram_re       = rd_req & ~empty & ~rst & ~flush;
    ram_waddr    = wptr[ADDR_WIDTH-1:0];
    ram_raddr    = rptr[ADDR_WIDTH-1:0];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      wptr      <= wptr + CW'(ram_we);
      rptr      <= rptr + CW'(ram_re);
      count     <= count + CW'(ram_we) - CW'(ram_re);
      overflow  <= (wr_req & full) | (overflow & ~clr_err);
      underflow <= (rd_req & empty) | (underflow & ~clr_err);
    end
  end
endmodule

// File: tb/tb_fifo_ctrl.sv
// tb_fifo_ctrl: directed and randomized checks of fifo_ctrl against a count/index reference model
module tb_fifo_ctrl;
  localparam int DEPTH = 16;
  logic clk = 1'b0;
  logic rst, flush, wr_req, rd_req, clr_err;
  logic ram_we, ram_re, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [3:0] ram_waddr, ram_raddr;
  logic [4:0] count;
  int checks = 0;
  int passed = 0;
  int m_cnt = 0, m_wa = 0, m_ra = 0;
  bit m_ov = 0, m_un = 0;
  always #5 clk = ~clk;
  fifo_ctrl #(.ADDR_WIDTH(4), .AFULL_TH(12), .AEMPTY_TH(2)) dut (
    .clk(clk), .rst(rst), .flush(flush), .wr_req(wr_req), .rd_req(rd_req), .clr_err(clr_err),
    .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_re(ram_re), .ram_raddr(ram_raddr),
    .count(count), .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .overflow(overflow), .underflow(underflow)
  );
  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d cnt=%0d t=%0t", tag, obs, exp, m_cnt, $time);
  endtask
  task automatic cyc(input bit w, input bit r, input bit c, input bit f, input bit rs);
    bit ew, er;
    @(negedge clk);
    wr_req = w; rd_req = r; clr_err = c; flush = f; rst = rs;
    ew = w && m_cnt < DEPTH && !rs && !f;
    er = r && m_cnt > 0 && !rs && !f;
    #1;
    chk("ram_we", int'(ram_we), int'(ew));
    chk("ram_re", int'(ram_re), int'(er));
    chk("ram_waddr", int'(ram_waddr), m_wa);
    chk("ram_raddr", int'(ram_raddr), m_ra);
    chk("count", int'(count), m_cnt);
    chk("full", int'(full), int'(m_cnt == DEPTH));
    chk("empty", int'(empty), int'(m_cnt == 0));
    chk("almost_full", int'(almost_full), int'(m_cnt >= 12));
    chk("almost_empty", int'(almost_empty), int'(m_cnt <= 2));
    chk("overflow", int'(overflow), int'(m_ov));
    chk("underflow", int'(underflow), int'(m_un));
    @(posedge clk);
    if (rs) begin
      m_cnt = 0; m_wa = 0; m_ra = 0; m_ov = 0; m_un = 0;
    end else if (f) begin
      m_cnt = 0; m_wa = 0; m_ra = 0;
    end else begin
      m_ov = (w && m_cnt == DEPTH) || (m_ov && !c);
      m_un = (r && m_cnt == 0) || (m_un && !c);
      m_wa = (m_wa + int'(ew)) % DEPTH;
      m_ra = (m_ra + int'(er)) % DEPTH;
      m_cnt = m_cnt + int'(ew) - int'(er);
    end
  endtask
  initial begin
    rst = 1'b1; flush = 1'b0; wr_req = 1'b1; rd_req = 1'b1; clr_err = 1'b0;
    @(posedge clk);
    cyc(0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    for (int i = 0; i < 15; i++) cyc(0, 1, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 1, 0, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 40; i++) cyc(1, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 1, 0, 1, 0);
    cyc(0, 0, 0, 0, 0);
    for (int i = 0; i < 9; i++) cyc(1, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 1);
    cyc(0, 0, 0, 0, 0);
    for (int i = 0; i < 600; i++) begin
      int p;
      p = (i / 100) % 3;
      cyc($urandom_range(0, 99) < (p == 0 ? 70 : p == 1 ? 30 : 50),
          $urandom_range(0, 99) < (p == 0 ? 30 : p == 1 ? 70 : 50),
          $urandom_range(0, 99) < 5, $urandom_range(0, 99) < 2, $urandom_range(0, 99) < 1);
    end
    cyc(0, 0, 0, 0, 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
